// File: rtl/pc_update_unit.sv
// pc_update_unit: KGP-RISC PC owner, fetch sequencer and branch resolver.
// Optional feature macro: PC_MISALIGN_TRAP_EN (jr to an unaligned target halts and sets misalign_err).
module pc_update_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic        dec_valid,
   input  logic [2:0]  br_op,
   input  logic        is_jr,
   input  logic [31:0] jr_target,
   input  logic [31:0] offset_ext,
   input  logic        flag_z,
   input  logic        flag_c,
   input  logic        flag_s,
   input  logic        halt,
   output logic [31:0] pc,
   output logic        link_we,
   output logic [31:0] link_data,
   output logic        taken,
`ifdef PC_MISALIGN_TRAP_EN
   output logic        misalign_err,
`endif
   output logic        halted
);
   typedef enum logic [1:0] {FETCH, DECODE, UPDATE, HALT} state_t;
   state_t state, state_nx;
   logic [2:0]  op_r;
   logic        jr_r, z_r, c_r, s_r;
   logic [31:0] tgt_r, off_r;
   logic [31:0] pc4, br_tgt, jr_addr, pc_nx;
   logic        cond, redirect, jr_bad, is_bl;
   assign imem_addr = pc;
   assign halted = state == HALT;
   assign is_bl = op_r == 3'd2;
`ifdef PC_MISALIGN_TRAP_EN
   assign jr_bad = jr_r && (tgt_r[1:0] != 2'b00);
   assign jr_addr = tgt_r;
`else
   assign jr_bad = 1'b0;
   assign jr_addr = {tgt_r[31:2], 2'b00};
`endif
   // Branch resolution from the latched decode bundle, and next-state selection.
   always_comb begin
      pc4 = pc + 32'd4;
      br_tgt = pc4 + {off_r[29:0], 2'b00};
      cond = (op_r == 3'd1) || (op_r == 3'd2) ||
             (op_r == 3'd3 && z_r) || (op_r == 3'd4 && !z_r) ||
             (op_r == 3'd5 && c_r) || (op_r == 3'd6 && !c_r) ||
             (op_r == 3'd7 && s_r);
      redirect = jr_r || cond;
      pc_nx = jr_r ? jr_addr : cond ? br_tgt : pc4;
      state_nx = state;
      case (state)
         FETCH:   state_nx = (imem_req && imem_ack) ? DECODE : FETCH;
         DECODE:  state_nx = dec_valid ? (halt ? HALT : UPDATE) : DECODE;
         UPDATE:  state_nx = jr_bad ? HALT : FETCH;
         default: state_nx = HALT;
      endcase
   end
   // State, PC, fetch request and one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
         pc <= RESET_VECTOR;
         imem_req <= 1'b0;
         link_we <= 1'b0;
         link_data <= 32'h0;
         taken <= 1'b0;
      end else begin
         state <= state_nx;
         imem_req <= state_nx == FETCH;
         link_we <= state == UPDATE && is_bl;
         taken <= state == UPDATE && !jr_bad && redirect;
         if (state == UPDATE && !jr_bad) pc <= pc_nx;
         if (state == UPDATE && is_bl) link_data <= pc4;
      end
   end
   // Decode bundle is captured only when DECODE sees dec_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r <= 3'd0;
         jr_r <= 1'b0;
         tgt_r <= 32'h0;
         off_r <= 32'h0;
         z_r <= 1'b0;
         c_r <= 1'b0;
         s_r <= 1'b0;
      end else if (state == DECODE && dec_valid) begin
         op_r <= br_op;
         jr_r <= is_jr;
         tgt_r <= jr_target;
         off_r <= offset_ext;
         z_r <= flag_z;
         c_r <= flag_c;
         s_r <= flag_s;
      end
   end
`ifdef PC_MISALIGN_TRAP_EN
   // Sticky misaligned-jr flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign_err <= 1'b0;
      else if (state == UPDATE && jr_bad) misalign_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: randomized and directed checks of pc_update_unit against a reference model.
module tb_pc_update_unit;
   localparam logic [31:0] RV = 32'h100;
   logic clk = 0, rst_n = 0, imem_ack = 0, dec_valid = 0, is_jr = 0;
   logic flag_z = 0, flag_c = 0, flag_s = 0, halt = 0;
   logic [2:0] br_op = 0;
   logic [31:0] jr_target = 0, offset_ext = 0;
   logic imem_req, link_we, taken, halted;
   logic [31:0] imem_addr, pc, link_data;
`ifdef PC_MISALIGN_TRAP_EN
   logic misalign_err;
`endif
   int checks = 0, errors = 0;
   logic [31:0] exp_pc = RV, exp_ld = 0;

   pc_update_unit #(.RESET_VECTOR(RV)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .dec_valid(dec_valid), .br_op(br_op), .is_jr(is_jr), .jr_target(jr_target),
      .offset_ext(offset_ext), .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .halt(halt),
      .pc(pc), .link_we(link_we), .link_data(link_data), .taken(taken),
`ifdef PC_MISALIGN_TRAP_EN
      .misalign_err(misalign_err),
`endif
      .halted(halted));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic scramble();
      br_op = 3'($urandom);
      is_jr = 1'($urandom);
      jr_target = $urandom;
      offset_ext = $urandom;
      {flag_z, flag_c, flag_s, halt} = 4'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      imem_ack = 1;
      rst_n = 0;
      #1;
      chk("rst_pc", pc, RV);
      chk("rst_req", imem_req, 0);
      chk("rst_taken", taken, 0);
      chk("rst_lw", link_we, 0);
      chk("rst_ld", link_data, 0);
      chk("rst_halted", halted, 0);
`ifdef PC_MISALIGN_TRAP_EN
      chk("rst_mis", misalign_err, 0);
`endif
      @(negedge clk);
      imem_ack = 0;
      rst_n = 1;
      @(negedge clk);
      chk("rel_req", imem_req, 1);
      chk("rel_pc", pc, RV);
      exp_pc = RV;
      exp_ld = 0;
   endtask

   // Precondition: at a negedge in FETCH with imem_req high.
   task automatic do_instr(input logic [2:0] op, input logic jr, input logic [31:0] tgt,
                           input logic [31:0] off, input logic z, input logic c, input logic s,
                           input logic h, input int ad, input int dd);
      logic [31:0] pc0, nx;
      logic tk, trap;
      pc0 = exp_pc;
      case (op)
         3'd1, 3'd2: tk = 1;
         3'd3: tk = z;
         3'd4: tk = !z;
         3'd5: tk = c;
         3'd6: tk = !c;
         3'd7: tk = s;
         default: tk = 0;
      endcase
      nx = tk ? pc0 + 4 + off * 4 : pc0 + 4;
      trap = 0;
      if (jr) begin
         tk = 1;
         nx = tgt - (tgt % 4);
`ifdef PC_MISALIGN_TRAP_EN
         trap = (tgt % 4) != 0;
`endif
      end
      chk("fetch_addr", imem_addr, pc0);
      chk("fetch_req", imem_req, 1);
      for (int i = 0; i < ad; i++) begin
         imem_ack = 0;
         @(negedge clk);
         chk("stall_req", imem_req, 1);
         chk("stall_pc", pc, pc0);
      end
      imem_ack = 1;
      @(negedge clk);
      imem_ack = 0;
      chk("dec_req", imem_req, 0);
      chk("tk_pulse", taken, 0);
      chk("lw_pulse", link_we, 0);
      for (int i = 0; i < dd; i++) begin
         scramble();
         @(negedge clk);
         chk("dec_hold_pc", pc, pc0);
         chk("dec_hold_req", imem_req, 0);
      end
      br_op = op; is_jr = jr; jr_target = tgt; offset_ext = off;
      flag_z = z; flag_c = c; flag_s = s; halt = h;
      dec_valid = 1;
      @(negedge clk);
      dec_valid = 0;
      scramble();
      if (h || trap) begin
         if (trap) @(negedge clk);
         for (int i = 0; i < 10; i++) begin
            chk("halt_flag", halted, 1);
            chk("halt_req", imem_req, 0);
            chk("halt_pc", pc, pc0);
`ifdef PC_MISALIGN_TRAP_EN
            chk("halt_mis", misalign_err, trap);
`endif
            @(negedge clk);
         end
      end else begin
         chk("upd_halted", halted, 0);
         @(negedge clk);
         if (op == 3'd2) exp_ld = pc0 + 4;
         chk("new_pc", pc, nx);
         chk("taken", taken, tk);
         chk("link_we", link_we, op == 3'd2);
         chk("link_data", link_data, exp_ld);
         chk("new_req", imem_req, 1);
         exp_pc = nx;
      end
   endtask

   initial begin
      logic [31:0] t;
      @(negedge clk);
      chk("init_pc", pc, RV);
      chk("init_req", imem_req, 0);
      chk("init_halted", halted, 0);
      do_reset();
      do_instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 5, 4);
      chk("seq_pc", exp_pc, 32'h104);
      do_instr(3'd0, 1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
      do_instr(3'd3, 0, 0, 32'hFFFF_FFFE, 1, 0, 0, 0, 0, 0);
      chk("bz_pc", pc, 32'h1FC);
      do_instr(3'd0, 1, 32'h200, 0, 0, 0, 0, 0, 1, 1);
      do_instr(3'd3, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 0, 0, 0);
      chk("bnz_pc", pc, 32'h204);
      do_instr(3'd0, 1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
      do_instr(3'd2, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      chk("bl_pc", pc, 32'h344);
      chk("bl_ld", link_data, 32'h304);
      do_instr(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      do_instr(3'd2, 1, 32'h500, 32'h10, 0, 0, 0, 0, 0, 0);
      chk("bljr_ld", link_data, 32'h34C);
      do_instr(3'd0, 1, 32'h403, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
      do_reset();
`else
      chk("jr_mask_pc", pc, 32'h400);
`endif
      do_instr(3'd0, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
      do_instr(3'd1, 0, 0, 32'hFFFF_FFF0, 0, 0, 0, 0, 0, 0);
      chk("wrap_pc", pc, 32'hFFFF_FFCC);
      for (int n = 0; n < 40; n++) begin
         t = $urandom;
`ifdef PC_MISALIGN_TRAP_EN
         t[1:0] = 2'b00;
`endif
         do_instr(3'($urandom), ($urandom % 6) == 0, t,
                  ($urandom % 2) ? $urandom : 32'($signed(6'($urandom))),
                  1'($urandom), 1'($urandom), 1'($urandom), 0,
                  $urandom_range(0, 2), $urandom_range(0, 2));
      end
      do_instr(3'd0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0);
      do_reset();
      do_instr(3'd1, 0, 0, 32'h7, 0, 0, 0, 1, 1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
